alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter feeding a two-stage 32-bit ALU pipeline (issue reg S1, result reg S2).
// Optional macro ALU_ARBITER_ERR_EN adds output rsp_err flagging undefined opcodes.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_a,
  input  logic [NUM_REQ-1:0][31:0]  req_b,
  input  logic [NUM_REQ-1:0][3:0]   req_opcode,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [31:0]               rsp_result,
  output logic                      rsp_zero
`ifdef ALU_ARBITER_ERR_EN
  ,
  output logic                      rsp_err
`endif
);

  localparam int DATA_W = 32;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  function automatic logic [DATA_W-1:0] alu_calc(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [3:0]        op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic op_undef(input logic [3:0] op);
    return !(op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB);
  endfunction

  logic [IDW-1:0]    r_last;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [3:0]        r_op_p1;
  logic [IDW-1:0]    r_id_p1;
  logic              r_vld_p2;
  logic [DATA_W-1:0] r_res_p2;
  logic              r_zero_p2;
  logic [IDW-1:0]    r_id_p2;

  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW-1:0]    w_idx;
  logic              w_s1_adv;
  logic              w_s1_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_res;

  // Round-robin search: descending loop so the nearest requester after r_last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  assign w_s1_adv  = r_vld_p1 && (!r_vld_p2 || rsp_ready);
  assign w_s1_free = !r_vld_p1 || w_s1_adv;
  assign w_accept  = w_gnt_vld && w_s1_free && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_id] = 1'b1;
  end

  // Stage p1: issue register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_last   <= IDW'(NUM_REQ - 1);
    end else begin
      r_vld_p1 <= w_accept || (r_vld_p1 && !w_s1_adv);
      if (w_accept) r_last <= w_gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p1  <= req_a[w_gnt_id];
      r_b_p1  <= req_b[w_gnt_id];
      r_op_p1 <= req_opcode[w_gnt_id];
      r_id_p1 <= w_gnt_id;
    end
  end

  assign w_res = alu_calc(r_a_p1, r_b_p1, r_op_p1);

  // Stage p2: result register, drives the response port directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_res_p2  <= '0;
      r_zero_p2 <= 1'b0;
      r_id_p2   <= '0;
    end else begin
      r_vld_p2 <= w_s1_adv || (r_vld_p2 && !rsp_ready);
      if (w_s1_adv) begin
        r_res_p2  <= w_res;
        r_zero_p2 <= (w_res == '0);
        r_id_p2   <= r_id_p1;
      end
    end
  end

`ifdef ALU_ARBITER_ERR_EN
  logic r_err_p2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_p2 <= 1'b0;
    else if (w_s1_adv) r_err_p2 <= op_undef(r_op_p1);
  end
  assign rsp_err = r_err_p2;
`endif

  assign rsp_valid  = r_vld_p2;
  assign rsp_id     = r_id_p2;
  assign rsp_result = r_res_p2;
  assign rsp_zero   = r_zero_p2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal cases plus randomized traffic against a queue-based reference model.
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic [N-1:0][3:0]    req_opcode;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_zero;
`ifdef ALU_ARBITER_ERR_EN
  logic                 rsp_err;
`endif

  alu_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARBITER_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           zero;
    logic           err;
  } rsp_t;

  rsp_t  mq[$];      // operations accepted and not yet consumed, oldest first
  bit    m_hv;       // oldest entry is currently presented on the response port
  int    m_last;
  bit    m_s1_full, m_s1_adv, m_can;
  int    m_g;
  logic [31:0] m_exp_ready;
  rsp_t  m_new;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_hv   = 1'b0;
      m_last = N - 1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    end else begin
      m_s1_full = (mq.size() == 2) || (mq.size() == 1 && !m_hv);
      m_s1_adv  = m_s1_full && (!m_hv || rsp_ready);
      m_can     = !m_s1_full || m_s1_adv;
      m_g = -1;
      for (int k = 1; k <= N; k++)
        if (m_g < 0 && req_valid[2'((m_last + k) % N)]) m_g = (m_last + k) % N;
      m_exp_ready = (m_can && m_g >= 0) ? (32'd1 << m_g) : 32'd0;
      chk("req_ready", 32'(req_ready), m_exp_ready);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_hv));
      if (m_hv && mq.size() > 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
        chk("rsp_result", rsp_result, mq[0].res);
        chk("rsp_zero", 32'(rsp_zero), 32'(mq[0].zero));
`ifdef ALU_ARBITER_ERR_EN
        chk("rsp_err", 32'(rsp_err), 32'(mq[0].err));
`endif
      end
      if (m_hv && rsp_ready) begin
        void'(mq.pop_front());
        m_hv = 1'b0;
      end
      if (m_s1_adv) m_hv = 1'b1;
      if (m_exp_ready != 0) begin
        m_new.id   = IDW'(m_g);
        m_new.res  = ref_alu(req_a[m_g], req_b[m_g], req_opcode[m_g]);
        m_new.zero = (m_new.res == 32'd0);
        m_new.err  = !(req_opcode[m_g] inside {4'd0, 4'd1, 4'd2, 4'd6});
        mq.push_back(m_new);
        m_last = m_g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic set_one(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    req_a[i]     = a;
    req_b[i]     = b;
    req_opcode[i] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic op_case(input string nm, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp_res, input logic exp_zero);
    set_one(i, a, b, op);
    step();
    idle();
    chk({nm, "_not_yet"}, 32'(rsp_valid), 32'd0);
    step();
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_id"}, 32'(rsp_id), 32'(i));
    chk({nm, "_result"}, rsp_result, exp_res);
    chk({nm, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom % 4)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom % 8);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    case ($urandom % 5)
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return 4'd6;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);

    op_case("add_wrap", 1, 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'h0000_0001, 1'b0);
    op_case("sub_eq", 2, 32'd5, 32'd5, 4'b0110, 32'h0, 1'b1);
    op_case("sub_borrow", 3, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0);
    op_case("and_op", 0, 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0000, 32'h00F0_1200, 1'b0);
    op_case("or_op", 1, 32'hF000_0001, 32'h0000_0F00, 4'b0001, 32'hF000_0F01, 1'b0);
    op_case("undef_op", 2, 32'h1234_5678, 32'h1, 4'b0101, 32'h0, 1'b1);
`ifdef ALU_ARBITER_ERR_EN
    chk("undef_err", 32'(rsp_err), 32'd1);
`endif
    step();

    // round-robin with all requesters active
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'(i + 10);
      req_b[i] = 32'd1;
      req_opcode[i] = 4'b0010;
    end
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'd1 << (c % N));
      step();
    end
    chk("rr_stream_id", 32'(rsp_id), 32'd3);
    chk("rr_stream_result", rsp_result, 32'd14);
    idle();
    step();
    step();
    step();

    // backpressure with both stages full (last grant is 0 here)
    set_one(1, 32'd1, 32'd1, 4'b0010);
    step();
    set_one(2, 32'd2, 32'd2, 4'b0010);
    step();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_id", 32'(rsp_id), 32'd1);
      chk("stall_result", rsp_result, 32'd2);
      step();
    end
    rsp_ready = 1'b1;
    idle();
    step();
    chk("drain2_id", 32'(rsp_id), 32'd2);
    chk("drain2_result", rsp_result, 32'd4);
    step();
    chk("drain_empty", 32'(rsp_valid), 32'd0);

    // reset with both stages full
    set_one(3, 32'd7, 32'd1, 4'b0110);
    step();
    set_one(0, 32'd3, 32'd3, 4'b0000);
    step();
    rsp_ready = 1'b0;
    req_valid = '1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("postrst_grant", 32'(req_ready), 32'd1);
    step();
    idle();
    step();
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = (($urandom % 200) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i] = pick32();
        req_b[i] = pick32();
        req_opcode[i] = pick_op();
      end
      rsp_ready = (($urandom % 10) < 7);
      step();
    end
    rst = 1'b0;
    idle();
    rsp_ready = 1'b1;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
